// File: rtl/soc_system_pll_pkg.sv
// rtl/soc_system_pll_pkg.sv - shared state encoding and parameter defaults for the PLL lock controller
//   No ports: provides pll_state_e, default cycle counts and the max3() sizing helper.
package soc_system_pll_pkg;

  localparam int unsigned PLL_RST_CYCLES_DEF      = 16;
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 65536;
  localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 1024;
  localparam int unsigned MAX_RETRIES_DEF         = 3;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/soc_system_sync2.sv
// rtl/soc_system_sync2.sv - two-flop synchronizer for a single asynchronous level
//   clk : destination clock
//   rst : asynchronous active-high reset, both flops clear to 0
//   d   : asynchronous input level
//   q   : synchronized level, two clk cycles after d
module soc_system_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/soc_system_pll_lock_ctrl.sv
// rtl/soc_system_pll_lock_ctrl.sv - PLL reset sequencing, lock qualification and retry control
//   refclk     : the only clock
//   rst        : asynchronous active-high reset
//   pll_locked : PLL lock indication, asynchronous, synchronized internally
//   retry_req  : single-cycle restart request, honoured in every state
//   pll_rst    : PLL reset, high only while sequencing a PLL reset pulse
//   sys_reset  : downstream reset, low only when locked and stable
//   ready      : clocks locked and stable
//   lock_fail  : retries exhausted
//   loss_count : saturating count of lock-loss events while running
//   state      : debug view of the FSM state
module soc_system_pll_lock_ctrl
  import soc_system_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRIES         = MAX_RETRIES_DEF
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_fail,
  output logic [7:0] loss_count,
  output logic [2:0] state
);

  localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees locked_s is the first qualified cycle,
  // so STABLE itself only needs LOCK_STABLE_CYCLES-1 more.
  localparam logic [CNT_W-1:0]   STABLE_LAST  =
      CNT_W'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic                locked_s;
  pll_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic [7:0]          loss_count_q, loss_count_d;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_reset_q, sys_reset_d;
  logic                ready_q, ready_d;
  logic                lock_fail_q, lock_fail_d;

  soc_system_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // FSM and counter next-state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    retry_cnt_d  = retry_cnt_q;
    loss_count_d = loss_count_q;

    if (retry_req) begin
      // Restart wins over everything, including a same-cycle lock loss.
      state_d     = ST_PLL_RST;
      cnt_d       = '0;
      retry_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = (LOCK_STABLE_CYCLES <= 1) ? ST_RUN : ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_cnt_q < RETRY_MAX) begin
              state_d     = ST_PLL_RST;
              retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d = ST_PLL_RST;
            if (loss_count_q != 8'hFF) begin
              loss_count_d = loss_count_q + 8'd1;
            end
          end
        end
        ST_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end

    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      retry_cnt_d = '0;
    end
  end

  // Output decode from the next state so the outputs are registered alongside it
  always_comb begin
    pll_rst_d   = (state_d == ST_PLL_RST);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    lock_fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retry_cnt_q  <= '0;
      loss_count_q <= '0;
      pll_rst_q    <= 1'b1;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      lock_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      loss_count_q <= loss_count_d;
      pll_rst_q    <= pll_rst_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      lock_fail_q  <= lock_fail_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_reset  = sys_reset_q;
  assign ready      = ready_q;
  assign lock_fail  = lock_fail_q;
  assign loss_count = loss_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_soc_system_pll_lock_ctrl.sv
// tb/tb_soc_system_pll_lock_ctrl.sv - directed self-checking bench for soc_system_pll_lock_ctrl
module tb_soc_system_pll_lock_ctrl;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       retry_req;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       lock_fail;
  logic [7:0] loss_count;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] S_PLL_RST = 0;
  localparam logic [31:0] S_WAIT    = 1;
  localparam logic [31:0] S_STABLE  = 2;
  localparam logic [31:0] S_RUN     = 3;
  localparam logic [31:0] S_FAIL    = 4;

  soc_system_pll_lock_ctrl #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .retry_req  (retry_req),
    .pll_rst    (pll_rst),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .lock_fail  (lock_fail),
    .loss_count (loss_count),
    .state      (state)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int rises;
    int fail_at;
    int bound_err;
    logic prev;

    rst = 1'b1;
    pll_locked = 1'b0;
    retry_req = 1'b0;
    tick(3);

    chk("rst_state",      {29'd0, state},     S_PLL_RST);
    chk("rst_pll_rst",    {31'd0, pll_rst},   32'd1);
    chk("rst_sys_reset",  {31'd0, sys_reset}, 32'd1);
    chk("rst_ready",      {31'd0, ready},     32'd0);
    chk("rst_lock_fail",  {31'd0, lock_fail}, 32'd0);
    chk("rst_loss_count", {24'd0, loss_count}, 32'd0);

    // Normal bring-up: lock rises 10 cycles after release
    rst = 1'b0;
    #1;
    hi = pll_rst ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (pll_rst) hi++;
      if (i == 4) chk("bringup_wait_state", {29'd0, state}, S_WAIT);
    end
    chk("bringup_pll_rst_cycles", hi, 32'd4);
    pll_locked = 1'b1;
    tick(9);
    chk("bringup_ready_early", {31'd0, ready}, 32'd0);
    chk("bringup_state_stable", {29'd0, state}, S_STABLE);
    tick(1);
    chk("bringup_ready", {31'd0, ready}, 32'd1);
    chk("bringup_sys_reset", {31'd0, sys_reset}, 32'd0);
    chk("bringup_state_run", {29'd0, state}, S_RUN);

    // Lock loss while running
    tick(2);
    pll_locked = 1'b0;
    tick(2);
    chk("loss_sys_reset_hold", {31'd0, sys_reset}, 32'd0);
    tick(1);
    chk("loss_sys_reset", {31'd0, sys_reset}, 32'd1);
    chk("loss_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("loss_count_1", {24'd0, loss_count}, 32'd1);

    // Re-lock with a one-cycle glitch after 5 qualified cycles
    pll_locked = 1'b1;
    tick(7);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(4);
    chk("glitch_ready_blocked", {31'd0, ready}, 32'd0);
    chk("glitch_state_stable", {29'd0, state}, S_STABLE);
    tick(5);
    chk("glitch_ready_early", {31'd0, ready}, 32'd0);
    tick(1);
    chk("glitch_ready", {31'd0, ready}, 32'd1);
    chk("glitch_loss_count", {24'd0, loss_count}, 32'd1);

    // Lock lost for good: three reset pulses then FAIL
    tick(1);
    pll_locked = 1'b0;
    prev = pll_rst;
    rises = 0;
    hi = 0;
    fail_at = 0;
    for (int i = 1; i <= 150; i++) begin
      tick(1);
      if (pll_rst && !prev) rises++;
      if (pll_rst) hi++;
      if (lock_fail && fail_at == 0) fail_at = i;
      prev = pll_rst;
    end
    chk("fail_pulses", rises, 32'd3);
    chk("fail_pll_rst_cycles", hi, 32'd12);
    chk("fail_entry_cycle", fail_at, 32'd111);
    chk("fail_state", {29'd0, state}, S_FAIL);
    chk("fail_lock_fail", {31'd0, lock_fail}, 32'd1);
    chk("fail_pll_rst_low", {31'd0, pll_rst}, 32'd0);
    chk("fail_sys_reset", {31'd0, sys_reset}, 32'd1);
    chk("fail_loss_count", {24'd0, loss_count}, 32'd2);

    // Recovery from FAIL
    retry_req = 1'b1;
    tick(1);
    retry_req = 1'b0;
    chk("recover_lock_fail", {31'd0, lock_fail}, 32'd0);
    chk("recover_state", {29'd0, state}, S_PLL_RST);
    pll_locked = 1'b1;
    hi = pll_rst ? 1 : 0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (pll_rst) hi++;
    end
    chk("recover_pll_rst_cycles", hi, 32'd4);
    tick(4);
    chk("recover_ready_early", {31'd0, ready}, 32'd0);
    tick(1);
    chk("recover_ready", {31'd0, ready}, 32'd1);

    // retry_req coinciding with the lock-loss decision: loss is not counted
    tick(1);
    pll_locked = 1'b0;
    tick(2);
    retry_req = 1'b1;
    tick(1);
    retry_req = 1'b0;
    chk("prio_state", {29'd0, state}, S_PLL_RST);
    chk("prio_loss_count", {24'd0, loss_count}, 32'd2);
    pll_locked = 1'b1;
    wait_ready("prio_relock_ready");

    // Saturation of loss_count
    bound_err = 0;
    for (int ev = 1; ev <= 300; ev++) begin
      int n;
      pll_locked = 1'b0;
      n = 0;
      while (sys_reset !== 1'b1 && n < 10) begin tick(1); n++; end
      if (n >= 10) bound_err++;
      pll_locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin tick(1); n++; end
      if (n >= 40) bound_err++;
      if (ev == 252) chk("sat_loss_254", {24'd0, loss_count}, 32'd254);
      if (ev == 253) chk("sat_loss_255", {24'd0, loss_count}, 32'd255);
    end
    chk("sat_bounds", bound_err, 32'd0);
    chk("sat_loss_final", {24'd0, loss_count}, 32'd255);

    // Asynchronous reset between clock edges
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_sys_reset", {31'd0, sys_reset}, 32'd1);
    chk("async_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("async_ready", {31'd0, ready}, 32'd0);
    chk("async_state", {29'd0, state}, S_PLL_RST);
    chk("async_loss_count", {24'd0, loss_count}, 32'd0);
    tick(1);
    rst = 1'b0;
    #1;
    hi = pll_rst ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (pll_rst) hi++;
    end
    chk("async_rerun_pll_rst_cycles", hi, 32'd4);
    wait_ready("async_rerun_ready");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
